dft_sample_loader: RTL and testbench

- Input stage of the 8-point DFT datapath.
- Accepts a serial stream of ufix 4.4 samples over a valid/ready handshake and assembles them into an 8-sample frame.
- Holds the frame on parallel outputs x0..x7 until the downstream butterfly network accepts it.
- Feeds x0/x2/x4/x6 to the even 4-point butterfly and x1/x3/x5/x7 to the odd one, in natural time order.

---
 rtl/dft_sample_loader.sv | 139 +++++++++++++
 tb/tb_dft_sample_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dft_sample_loader.sv
// dft_sample_loader: input stage of the 8-point DFT datapath.
// Collects a serial stream of DATA_W-bit samples over valid/ready and
// presents an 8-sample frame on x0..x7 until the butterfly network takes it.
// Optional feature macro: DFT_LOADER_FLUSH_EN adds a 'flush' input that
// closes a partial frame early, zero-padding the remaining slots.
module dft_sample_loader #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
`ifdef DFT_LOADER_FLUSH_EN
  input  logic              flush,
`endif
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] x3,
  output logic [DATA_W-1:0] x4,
  output logic [DATA_W-1:0] x5,
  output logic [DATA_W-1:0] x6,
  output logic [DATA_W-1:0] x7,
  output logic [2:0]        fill_cnt
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [2:0]        cnt_r;
  logic [2:0]        cnt_nxt_s;
  logic              frm_valid_r;
  logic [DATA_W-1:0] slot_r     [8];
  logic [DATA_W-1:0] slot_nxt_s [8];
  logic              accept_s;
  logic              flush_go_s;

  // A held frame frees the loader in the same cycle it is consumed, so the
  // next frame's first sample can enter without a bubble.
  assign s_ready  = (state_r == FILL) | ((state_r == FULL) & frm_ready);
  assign accept_s = s_valid & s_ready;

`ifdef DFT_LOADER_FLUSH_EN
  // Flush only acts on a frame that has (or is just getting) some data.
  assign flush_go_s = (state_r == FILL) & flush & ((cnt_r != 3'd0) | accept_s);
`else
  assign flush_go_s = 1'b0;
`endif

  // Next-state, fill counter and slot contents.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    slot_nxt_s  = slot_r;

    case (state_r)
      FILL: begin
        if (flush_go_s) begin
          state_nxt_s = FULL;
          cnt_nxt_s   = 3'd0;
        end else if (accept_s) begin
          cnt_nxt_s = cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            state_nxt_s = FULL;
          end else begin
            state_nxt_s = FILL;
          end
        end else begin
          state_nxt_s = FILL;
        end
      end
      FULL: begin
        if (frm_ready) begin
          state_nxt_s = FILL;
          if (accept_s) begin
            cnt_nxt_s = 3'd1;
          end else begin
            cnt_nxt_s = 3'd0;
          end
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s = FILL;
        cnt_nxt_s   = 3'd0;
      end
    endcase

    // cnt_r is 0 in FULL, so an accept there naturally targets x0. A flush
    // zeroes every slot from the fill point upward, except a slot that the
    // same-cycle sample is writing.
    for (int i = 0; i < 8; i++) begin
      if (accept_s && (cnt_r == 3'(i))) begin
        slot_nxt_s[i] = s_data;
      end else if (flush_go_s && (3'(i) >= cnt_r)) begin
        slot_nxt_s[i] = '0;
      end else begin
        slot_nxt_s[i] = slot_r[i];
      end
    end
  end

  // State, counter, frame-valid flag and sample slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= FILL;
      cnt_r       <= 3'd0;
      frm_valid_r <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        slot_r[i] <= '0;
      end
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      frm_valid_r <= (state_nxt_s == FULL);
      for (int i = 0; i < 8; i++) begin
        slot_r[i] <= slot_nxt_s[i];
      end
    end
  end

  assign frm_valid = frm_valid_r;
  assign fill_cnt  = cnt_r;
  assign x0 = slot_r[0];
  assign x1 = slot_r[1];
  assign x2 = slot_r[2];
  assign x3 = slot_r[3];
  assign x4 = slot_r[4];
  assign x5 = slot_r[5];
  assign x6 = slot_r[6];
  assign x7 = slot_r[7];

endmodule

// File: tb/tb_dft_sample_loader.sv
// Directed self-checking bench for dft_sample_loader.
module tb_dft_sample_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       frm_valid;
  logic       frm_ready;
  logic [7:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic [2:0] fill_cnt;
`ifdef DFT_LOADER_FLUSH_EN
  logic       flush;
`endif

  logic [7:0] xv [8];
  int n_cmp = 0;
  int n_err = 0;

  assign xv[0] = x0; assign xv[1] = x1; assign xv[2] = x2; assign xv[3] = x3;
  assign xv[4] = x4; assign xv[5] = x5; assign xv[6] = x6; assign xv[7] = x7;

  dft_sample_loader #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef DFT_LOADER_FLUSH_EN
    .flush(flush),
`endif
    .frm_valid(frm_valid), .frm_ready(frm_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
    .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] base, input logic [7:0] step);
    logic [7:0] e;
    for (int k = 0; k < 8; k++) begin
      e = base + 8'(k) * step;
      chk($sformatf("%s_x%0d", tag, k), {24'd0, xv[k]}, {24'd0, e});
    end
  endtask

  initial begin
    int acc;
    int cyc;
    logic [7:0] d;

    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; frm_ready = 1'b0;
`ifdef DFT_LOADER_FLUSH_EN
    flush = 1'b0;
`endif
    tick(); tick();
    chk("rst_frm_valid", {31'd0, frm_valid}, 32'd0);
    chk("rst_fill_cnt", {29'd0, fill_cnt}, 32'd0);
    chk_frame("rst", 8'h00, 8'h00);
    rst = 1'b0;

    // Test 1: stream 0x10..0x80 with frm_ready held high.
    frm_ready = 1'b1; s_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_data = 8'(8'h10 * (k + 1));
      tick();
      chk($sformatf("t1_cnt%0d", k), {29'd0, fill_cnt}, 32'((k + 1) % 8));
      chk($sformatf("t1_fv%0d", k), {31'd0, frm_valid}, (k == 7) ? 32'd1 : 32'd0);
    end
    chk_frame("t1", 8'h10, 8'h10);
    s_valid = 1'b0;
    #1;
    chk("t1_s_ready_full", {31'd0, s_ready}, 32'd1);
    tick();
    chk("t1_fv_one_cycle", {31'd0, frm_valid}, 32'd0);

    // Test 2: hold a frame for 5 cycles against back-pressure.
    frm_ready = 1'b0; s_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_data = 8'h30 + 8'(k);
      tick();
    end
    chk("t2_fv", {31'd0, frm_valid}, 32'd1);
    s_data = 8'h55;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t2_s_ready%0d", c), {31'd0, s_ready}, 32'd0);
      tick();
      chk_frame($sformatf("t2_hold%0d", c), 8'h30, 8'h01);
      chk($sformatf("t2_fv_hold%0d", c), {31'd0, frm_valid}, 32'd1);
    end
    frm_ready = 1'b1;
    #1;
    chk("t2_s_ready_rel", {31'd0, s_ready}, 32'd1);
    tick();
    chk("t2_x0_new", {24'd0, x0}, 32'h55);
    chk("t2_x1_kept", {24'd0, x1}, 32'h31);
    chk("t2_cnt1", {29'd0, fill_cnt}, 32'd1);
    chk("t2_fv_drop", {31'd0, frm_valid}, 32'd0);
    frm_ready = 1'b0;
    for (int k = 1; k < 8; k++) begin
      s_data = 8'h55 + 8'(k);
      tick();
    end
    chk_frame("t2_next", 8'h55, 8'h01);
    s_valid = 1'b0; frm_ready = 1'b1;
    tick();

    // Test 3: 24 back-to-back samples, three frames 8 cycles apart.
    s_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      s_data = 8'h80 + 8'(i);
      tick();
      chk($sformatf("t3_cnt%0d", i), {29'd0, fill_cnt}, 32'((i + 1) % 8));
      chk($sformatf("t3_fv%0d", i), {31'd0, frm_valid}, (i % 8 == 7) ? 32'd1 : 32'd0);
      if (i % 8 == 7) begin
        d = 8'h80 + 8'(i - 7);
        chk_frame($sformatf("t3_f%0d", i / 8), d, 8'h01);
      end
    end
    s_valid = 1'b0;
    tick();
    chk("t3_end_fv", {31'd0, frm_valid}, 32'd0);

    // Test 4: asynchronous reset mid-frame.
    frm_ready = 1'b0; s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_data = 8'h11 + 8'(k);
      tick();
    end
    chk("t4_pre_cnt", {29'd0, fill_cnt}, 32'd5);
    s_valid = 1'b0;
    #2; rst = 1'b1; #1;
    chk("t4_cnt", {29'd0, fill_cnt}, 32'd0);
    chk("t4_fv", {31'd0, frm_valid}, 32'd0);
    chk_frame("t4_rst", 8'h00, 8'h00);
    tick();
    rst = 1'b0;
    s_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_data = 8'h21 + 8'(k);
      tick();
    end
    chk("t4_fv_after", {31'd0, frm_valid}, 32'd1);
    chk_frame("t4_clean", 8'h21, 8'h01);
    s_valid = 1'b0; frm_ready = 1'b1;
    tick();
    frm_ready = 1'b0;

    // Test 5: random gaps on s_valid, samples 0x01..0x08.
    acc = 0; cyc = 0;
    while (acc < 8 && cyc < 200) begin
      s_valid = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
      s_data  = 8'(acc + 1);
      tick();
      if (s_valid) acc++;
      cyc++;
      chk($sformatf("t5_cnt_c%0d", cyc), {29'd0, fill_cnt}, 32'(acc % 8));
    end
    chk("t5_accepted", 32'(acc), 32'd8);
    s_valid = 1'b0;
    chk("t5_fv", {31'd0, frm_valid}, 32'd1);
    chk_frame("t5", 8'h01, 8'h01);
    frm_ready = 1'b1;
    tick();
    frm_ready = 1'b0;

`ifdef DFT_LOADER_FLUSH_EN
    // Flush after three samples pads with zeros.
    s_valid = 1'b1;
    s_data = 8'hA0; tick();
    s_data = 8'hB0; tick();
    s_data = 8'hC0; tick();
    s_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_fv", {31'd0, frm_valid}, 32'd1);
    chk("fl_cnt", {29'd0, fill_cnt}, 32'd0);
    chk("fl_x0", {24'd0, x0}, 32'hA0);
    chk("fl_x1", {24'd0, x1}, 32'hB0);
    chk("fl_x2", {24'd0, x2}, 32'hC0);
    for (int k = 3; k < 8; k++) chk($sformatf("fl_x%0d", k), {24'd0, xv[k]}, 32'd0);
    frm_ready = 1'b1;
    tick();
    frm_ready = 1'b0;
    // Flush at fill_cnt 0 with no sample is ignored.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("fl0_fv", {31'd0, frm_valid}, 32'd0);
    chk("fl0_cnt", {29'd0, fill_cnt}, 32'd0);
    // Flush together with a sample keeps that sample.
    s_valid = 1'b1;
    s_data = 8'h01; tick();
    s_data = 8'hD0; flush = 1'b1; tick();
    s_valid = 1'b0; flush = 1'b0;
    chk("fls_fv", {31'd0, frm_valid}, 32'd1);
    chk("fls_x1", {24'd0, x1}, 32'hD0);
    chk("fls_x2", {24'd0, x2}, 32'd0);
    chk("fls_x7", {24'd0, x7}, 32'd0);
    frm_ready = 1'b1;
    tick();
    frm_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
